// File: rtl/axis_64to32.sv
// axis_64to32: 64-bit to 32-bit AXI-Stream down-converter for the VITA49
// unpack path. Each 64-bit input beat is held and replayed as two 32-bit
// words. TUSER is captured once per packet, and the block keeps a sticky
// oversize flag and a delivered-packet counter.
module axis_64to32 #(
  parameter int LOW_FIRST = 1,
  parameter int MAX_BEATS = 1024
) (
  input  logic        AXIS_ACLK,
  input  logic        AXIS_ARESETN,
  input  logic        S_AXIS_TVALID,
  output logic        S_AXIS_TREADY,
  input  logic [63:0] S_AXIS_TDATA,
  input  logic        S_AXIS_TLAST,
  input  logic [31:0] S_AXIS_TUSER,
  output logic        M_AXIS_TVALID,
  input  logic        M_AXIS_TREADY,
  output logic [31:0] M_AXIS_TDATA,
  output logic        M_AXIS_TLAST,
  output logic [31:0] M_AXIS_TUSER,
  output logic [31:0] PKT_COUNT,
  output logic        OVERSIZE
);

  localparam int CW = $clog2(MAX_BEATS) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BEATS - 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LO    = 2'd1,
    HI    = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [63:0]   data_q, data_d;
  logic          last_q, last_d;
  logic [31:0]   tuser_q, tuser_d;
  logic          sop_q, sop_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic [31:0]   pkt_count_q, pkt_count_d;
  logic          oversize_q, oversize_d;

  logic          s_ready;
  logic          s_xfr;
  logic          m_xfr;
  logic          m_last;
  logic [31:0]   first_word;
  logic [31:0]   second_word;

  // Handshakes and word selection; the input is only free once the second half is leaving
  always_comb begin
    s_ready     = (state_q == EMPTY) || ((state_q == HI) && M_AXIS_TREADY);
    s_xfr       = S_AXIS_TVALID && s_ready;
    m_xfr       = (state_q != EMPTY) && M_AXIS_TREADY;
    m_last      = (state_q == HI) && last_q;
    first_word  = (LOW_FIRST != 0) ? data_q[31:0]  : data_q[63:32];
    second_word = (LOW_FIRST != 0) ? data_q[63:32] : data_q[31:0];
  end

  // Next-state logic for the FSM, holding register, packet tracking and statistics
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    last_d      = last_q;
    tuser_d     = tuser_q;
    sop_d       = sop_q;
    beat_cnt_d  = beat_cnt_q;
    pkt_count_d = pkt_count_q;
    oversize_d  = oversize_q;

    case (state_q)
      EMPTY:   if (s_xfr) state_d = LO;
      LO:      if (m_xfr) state_d = HI;
      HI:      if (m_xfr) state_d = s_xfr ? LO : EMPTY;
      default: state_d = EMPTY;
    endcase

    if (s_xfr) begin
      data_d = S_AXIS_TDATA;
      last_d = S_AXIS_TLAST;
      sop_d  = S_AXIS_TLAST;
      if (sop_q) begin
        tuser_d = S_AXIS_TUSER;
      end
      if (S_AXIS_TLAST) begin
        beat_cnt_d = '0;
      end else if (beat_cnt_q == CNT_LAST) begin
        oversize_d = 1'b1;
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end

    if (m_xfr && m_last) begin
      pkt_count_d = pkt_count_q + 32'd1;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge AXIS_ACLK) begin
    if (!AXIS_ARESETN) begin
      state_q     <= EMPTY;
      data_q      <= '0;
      last_q      <= 1'b0;
      tuser_q     <= '0;
      sop_q       <= 1'b1;
      beat_cnt_q  <= '0;
      pkt_count_q <= '0;
      oversize_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      last_q      <= last_d;
      tuser_q     <= tuser_d;
      sop_q       <= sop_d;
      beat_cnt_q  <= beat_cnt_d;
      pkt_count_q <= pkt_count_d;
      oversize_q  <= oversize_d;
    end
  end

  assign S_AXIS_TREADY = s_ready;
  assign M_AXIS_TVALID = (state_q != EMPTY);
  assign M_AXIS_TDATA  = (state_q == LO) ? first_word :
                         (state_q == HI) ? second_word : 32'd0;
  assign M_AXIS_TLAST  = m_last;
  assign M_AXIS_TUSER  = tuser_q;
  assign PKT_COUNT     = pkt_count_q;
  assign OVERSIZE      = oversize_q;

endmodule
